// File: rtl/apb_intercon_rr.sv
// apb_intercon_rr
//   Round-robin APB interconnect: MASTER_PORTS upstream APB masters share one
//   downstream APB bus fanning out to SLAVE_PORTS slaves. The slave is chosen
//   by the PADDR field [DEC_LO +: SEL_BITS] of the granted master. Addresses
//   that decode past the last slave are answered locally with PSLVERR. An
//   ACCESS phase that outlasts TIMEOUT_CYCLES cycles is closed with PSLVERR
//   (TIMEOUT_CYCLES = 0 disables this).
//
// Ports
//   clk, reset                       clock (rising edge), async active-low reset
//   S_PADDR/S_PWDATA                 per-master address / write data (packed, master m at m*W)
//   S_PWRITE/S_PSELx/S_PENABLE       per-master APB controls
//   S_PRDATA/S_PREADY/S_PSLVERR      per-master response (zero for non-granted masters)
//   M_PADDR/M_PWRITE/M_PENABLE/M_PWDATA  shared downstream bus (zero when idle)
//   M_PSELx                          one-hot downstream slave select
//   M_PRDATA/M_PREADY                per-slave responses (packed, slave s at s*BUS_WIDTH)
module apb_intercon_rr #(
   parameter int MASTER_PORTS   = 2,
   parameter int SLAVE_PORTS    = 4,
   parameter int BUS_WIDTH      = 16,
   parameter int ADDR_WIDTH     = 16,
   parameter int DEC_LO         = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [MASTER_PORTS*ADDR_WIDTH-1:0] S_PADDR,
   input  logic [MASTER_PORTS-1:0]           S_PWRITE,
   input  logic [MASTER_PORTS-1:0]           S_PSELx,
   input  logic [MASTER_PORTS-1:0]           S_PENABLE,
   input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
   output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
   output logic [MASTER_PORTS-1:0]           S_PREADY,
   output logic [MASTER_PORTS-1:0]           S_PSLVERR,
   output logic [ADDR_WIDTH-1:0]             M_PADDR,
   output logic                              M_PWRITE,
   output logic                              M_PENABLE,
   output logic [BUS_WIDTH-1:0]              M_PWDATA,
   output logic [SLAVE_PORTS-1:0]            M_PSELx,
   input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]  M_PRDATA,
   input  logic [SLAVE_PORTS-1:0]            M_PREADY
);

   localparam int SEL_BITS = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
   localparam int GW       = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
   localparam int CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int MW       = MASTER_PORTS * BUS_WIDTH;
   // Counter value seen in the last allowed ACCESS cycle (first ACCESS cycle reads 0).
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

   state_t                  state, state_nx;
   logic [GW-1:0]           grant, last_grant;
   logic [SEL_BITS-1:0]     slv;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [BUS_WIDTH-1:0]    wdata_q;
   logic                    write_q;
   logic [CW-1:0]           tcnt;

   logic                    arb_found;
   logic [GW-1:0]           arb_idx;
   int unsigned             cand;
   logic [MASTER_PORTS-1:0] psel_shift;
   logic [MASTER_PORTS-1:0] wr_shift;
   logic [MASTER_PORTS-1:0] en_shift;
   logic [SLAVE_PORTS-1:0]  rdy_shift;
   logic [ADDR_WIDTH-1:0]   arb_addr;
   logic [BUS_WIDTH-1:0]    arb_wdata;
   logic                    arb_write;
   logic [SEL_BITS-1:0]     arb_sel;
   logic [31:0]             sel_ext;
   logic                    sel_ok;
   logic                    gnt_en;
   logic                    slv_rdy;
   logic [BUS_WIDTH-1:0]    slv_rdata;
   logic                    tmo;
   logic                    rsp_rdy;
   logic                    rsp_err;
   logic [BUS_WIDTH-1:0]    rsp_data;

   // Round-robin search starting just above the last granted master, with wrap.
   always_comb begin
      arb_found  = 1'b0;
      arb_idx    = '0;
      cand       = 0;
      psel_shift = '0;
      for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
         cand       = (32'(last_grant) + 32'd1 + i) % MASTER_PORTS;
         psel_shift = S_PSELx >> cand;
         if (!arb_found && psel_shift[0]) begin
            arb_found = 1'b1;
            arb_idx   = GW'(cand);
         end
      end
   end

   // Candidate master fields and slave decode.
   always_comb begin
      arb_addr  = ADDR_WIDTH'(S_PADDR >> (32'(arb_idx) * ADDR_WIDTH));
      arb_wdata = BUS_WIDTH'(S_PWDATA >> (32'(arb_idx) * BUS_WIDTH));
      wr_shift  = S_PWRITE >> arb_idx;
      arb_write = wr_shift[0];
      arb_sel   = arb_addr[DEC_LO +: SEL_BITS];
      sel_ext   = 32'(arb_sel);
      sel_ok    = (sel_ext < 32'(SLAVE_PORTS));
   end

   // Live view of the granted master and selected slave.
   always_comb begin
      en_shift  = S_PENABLE >> grant;
      gnt_en    = en_shift[0];
      rdy_shift = M_PREADY >> slv;
      slv_rdy   = rdy_shift[0];
      slv_rdata = BUS_WIDTH'(M_PRDATA >> (32'(slv) * BUS_WIDTH));
      tmo       = (TIMEOUT_CYCLES > 0) && (state == ACCESS) && !slv_rdy && (tcnt == TO_LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Grant bookkeeping, latched request and ACCESS cycle counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant      <= '0;
         last_grant <= GW'(MASTER_PORTS - 1);
         slv        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         tcnt       <= '0;
      end else begin
         if (state == IDLE && arb_found) begin
            grant      <= arb_idx;
            last_grant <= arb_idx;
            slv        <= arb_sel;
            addr_q     <= arb_addr;
            wdata_q    <= arb_wdata;
            write_q    <= arb_write;
         end
         if (state == ACCESS) begin
            tcnt <= tcnt + 1'b1;
         end else begin
            tcnt <= '0;
         end
      end
   end

   // Next state. ACCESS ends on downstream PREADY even if the master has let
   // go of PENABLE, so an abandoned transfer still completes on the bus.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (arb_found) state_nx = sel_ok ? SETUP : ERR;
         SETUP:   state_nx = ACCESS;
         ACCESS:  if (slv_rdy || tmo) state_nx = IDLE;
         ERR:     if (gnt_en) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      M_PSELx   = '0;
      M_PENABLE = 1'b0;
      M_PADDR   = '0;
      M_PWDATA  = '0;
      M_PWRITE  = 1'b0;
      rsp_rdy   = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = '0;
      case (state)
         SETUP: begin
            M_PSELx  = SLAVE_PORTS'(1'b1) << slv;
            M_PADDR  = addr_q;
            M_PWDATA = wdata_q;
            M_PWRITE = write_q;
         end
         ACCESS: begin
            if (tmo) begin
               rsp_rdy = 1'b1;
               rsp_err = 1'b1;
            end else begin
               M_PSELx   = SLAVE_PORTS'(1'b1) << slv;
               M_PENABLE = 1'b1;
               M_PADDR   = addr_q;
               M_PWDATA  = wdata_q;
               M_PWRITE  = write_q;
               rsp_rdy   = slv_rdy & gnt_en;
               rsp_data  = slv_rdata;
            end
         end
         ERR: begin
            rsp_rdy = gnt_en;
            rsp_err = gnt_en;
         end
         default: ;
      endcase
      S_PREADY  = rsp_rdy ? (MASTER_PORTS'(1'b1) << grant) : '0;
      S_PSLVERR = rsp_err ? (MASTER_PORTS'(1'b1) << grant) : '0;
      S_PRDATA  = MW'(rsp_data) << (32'(grant) * BUS_WIDTH);
   end

endmodule

// File: tb/tb_apb_intercon_rr.sv
// tb_apb_intercon_rr
//   Directed bench for apb_intercon_rr. Main instance uses default parameters;
//   a second instance with three slaves exercises the out-of-range decode path.
module tb_apb_intercon_rr;

   int n_cmp = 0;
   int n_err = 0;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // Main instance signals
   logic [31:0] s_paddr, s_pwdata, s_prdata;
   logic [1:0]  s_pwrite, s_psel, s_penable, s_pready, s_pslverr;
   logic [15:0] m_paddr, m_pwdata;
   logic        m_pwrite, m_penable;
   logic [3:0]  m_psel, m_pready;
   logic [63:0] m_prdata;

   // Three-slave instance signals
   logic [31:0] e_paddr, e_pwdata, e_prdata;
   logic [1:0]  e_pwrite, e_psel, e_penable, e_pready, e_pslverr;
   logic [15:0] e_mpaddr, e_mpwdata;
   logic        e_mpwrite, e_mpenable;
   logic [2:0]  e_mpsel, e_mpready;
   logic [47:0] e_mprdata;

   apb_intercon_rr dut (
      .clk(clk), .reset(reset),
      .S_PADDR(s_paddr), .S_PWRITE(s_pwrite), .S_PSELx(s_psel), .S_PENABLE(s_penable),
      .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata), .S_PREADY(s_pready), .S_PSLVERR(s_pslverr),
      .M_PADDR(m_paddr), .M_PWRITE(m_pwrite), .M_PENABLE(m_penable), .M_PWDATA(m_pwdata),
      .M_PSELx(m_psel), .M_PRDATA(m_prdata), .M_PREADY(m_pready)
   );

   apb_intercon_rr #(.SLAVE_PORTS(3)) dut3 (
      .clk(clk), .reset(reset),
      .S_PADDR(e_paddr), .S_PWRITE(e_pwrite), .S_PSELx(e_psel), .S_PENABLE(e_penable),
      .S_PWDATA(e_pwdata), .S_PRDATA(e_prdata), .S_PREADY(e_pready), .S_PSLVERR(e_pslverr),
      .M_PADDR(e_mpaddr), .M_PWRITE(e_mpwrite), .M_PENABLE(e_mpenable), .M_PWDATA(e_mpwdata),
      .M_PSELx(e_mpsel), .M_PRDATA(e_mprdata), .M_PREADY(e_mpready)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      s_paddr = '0; s_pwdata = '0; s_pwrite = '0; s_psel = '0; s_penable = '0;
      m_pready = '0; m_prdata = '0;
      e_paddr = '0; e_pwdata = '0; e_pwrite = '0; e_psel = '0; e_penable = '0;
      e_mpready = '0; e_mprdata = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b0000) begin n_err++; $display("FAIL reset_psel: got %b want 0000", m_psel); end
      n_cmp++; if (s_pready !== 2'b00) begin n_err++; $display("FAIL reset_pready: got %b want 00", s_pready); end
      n_cmp++; if (s_pslverr !== 2'b00) begin n_err++; $display("FAIL reset_pslverr: got %b want 00", s_pslverr); end
      n_cmp++; if (s_prdata !== 32'h0) begin n_err++; $display("FAIL reset_prdata: got %h want 0", s_prdata); end
      n_cmp++; if ({m_paddr, m_pwdata, m_pwrite, m_penable} !== 34'h0) begin
         n_err++; $display("FAIL reset_mbus: got %h/%h/%b/%b want zeros", m_paddr, m_pwdata, m_pwrite, m_penable);
      end
      n_cmp++; if (e_mpsel !== 3'b000) begin n_err++; $display("FAIL reset_psel3: got %b want 000", e_mpsel); end
      next_cycle();
      reset = 1'b1;
      next_cycle();
   endtask

   // Both masters request continuously; grants must alternate 0,1,0,1.
   task automatic test_round_robin();
      int          done;
      int          exp_m [4];
      bit          prev_done;
      logic [1:0]  fired;
      logic [1:0]  exp_rdy;
      logic [3:0]  exp_sel;
      logic [15:0] exp_data, got_data;
      exp_m = '{0, 1, 0, 1};
      done = 0;
      prev_done = 1'b0;
      clear_inputs();
      s_paddr  = {16'h3020, 16'h2010};
      m_prdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      m_pready = 4'b1111;
      s_psel   = 2'b11;
      for (int c = 0; c < 40 && done < 4; c++) begin
         fired = 2'b00;
         @(negedge clk);
         if (prev_done) begin
            n_cmp++; if (m_psel !== 4'b0000) begin n_err++; $display("FAIL rr_idle_gap: got %b want 0000", m_psel); end
         end
         prev_done = 1'b0;
         if (s_pready !== 2'b00) begin
            exp_rdy  = 2'b01 << exp_m[done];
            exp_sel  = (exp_m[done] == 0) ? 4'b0100 : 4'b1000;
            exp_data = (exp_m[done] == 0) ? 16'h3333 : 16'h4444;
            got_data = (exp_m[done] == 0) ? s_prdata[15:0] : s_prdata[31:16];
            n_cmp++; if (s_pready !== exp_rdy) begin n_err++; $display("FAIL rr_order[%0d]: got %b want %b", done, s_pready, exp_rdy); end
            n_cmp++; if (m_psel !== exp_sel) begin n_err++; $display("FAIL rr_psel[%0d]: got %b want %b", done, m_psel, exp_sel); end
            n_cmp++; if (got_data !== exp_data) begin n_err++; $display("FAIL rr_rdata[%0d]: got %h want %h", done, got_data, exp_data); end
            fired = s_pready;
            done++;
            prev_done = 1'b1;
         end
         next_cycle();
         s_penable = ~fired;
      end
      n_cmp++; if (done != 4) begin n_err++; $display("FAIL rr_count: got %0d want 4", done); end
      clear_inputs();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_single_write();
      clear_inputs();
      s_paddr[15:0]  = 16'h1004;
      s_pwdata[15:0] = 16'hBEEF;
      s_pwrite = 2'b01;
      s_psel   = 2'b01;
      m_pready = 4'b0010;
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b0000) begin n_err++; $display("FAIL wr_c1_psel: got %b want 0000", m_psel); end
      n_cmp++; if (s_pready !== 2'b00) begin n_err++; $display("FAIL wr_c1_pready: got %b want 00", s_pready); end
      next_cycle();
      s_penable = 2'b01;
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b0010) begin n_err++; $display("FAIL wr_setup_psel: got %b want 0010", m_psel); end
      n_cmp++; if (m_penable !== 1'b0) begin n_err++; $display("FAIL wr_setup_penable: got %b want 0", m_penable); end
      n_cmp++; if (m_paddr !== 16'h1004) begin n_err++; $display("FAIL wr_setup_paddr: got %h want 1004", m_paddr); end
      n_cmp++; if (m_pwdata !== 16'hBEEF) begin n_err++; $display("FAIL wr_setup_pwdata: got %h want beef", m_pwdata); end
      n_cmp++; if (m_pwrite !== 1'b1) begin n_err++; $display("FAIL wr_setup_pwrite: got %b want 1", m_pwrite); end
      n_cmp++; if (s_pready !== 2'b00) begin n_err++; $display("FAIL wr_setup_pready: got %b want 00", s_pready); end
      next_cycle();
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b0010) begin n_err++; $display("FAIL wr_acc_psel: got %b want 0010", m_psel); end
      n_cmp++; if (m_penable !== 1'b1) begin n_err++; $display("FAIL wr_acc_penable: got %b want 1", m_penable); end
      n_cmp++; if (m_paddr !== 16'h1004) begin n_err++; $display("FAIL wr_acc_paddr: got %h want 1004", m_paddr); end
      n_cmp++; if (s_pready !== 2'b01) begin n_err++; $display("FAIL wr_acc_pready: got %b want 01", s_pready); end
      n_cmp++; if (s_pslverr !== 2'b00) begin n_err++; $display("FAIL wr_acc_pslverr: got %b want 00", s_pslverr); end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b0000) begin n_err++; $display("FAIL wr_idle_psel: got %b want 0000", m_psel); end
      n_cmp++; if (m_paddr !== 16'h0) begin n_err++; $display("FAIL wr_idle_paddr: got %h want 0", m_paddr); end
      next_cycle();
   endtask

   // Three-slave instance: field value 3 has no slave.
   task automatic test_err();
      clear_inputs();
      e_paddr[15:0] = 16'h3000;
      e_psel    = 2'b01;
      e_mprdata = {16'hAAAA, 16'hBBBB, 16'hCCCC};
      e_mpready = 3'b111;
      @(negedge clk);
      n_cmp++; if (e_mpsel !== 3'b000) begin n_err++; $display("FAIL err_c1_psel: got %b want 000", e_mpsel); end
      next_cycle();
      @(negedge clk);
      n_cmp++; if (e_mpsel !== 3'b000) begin n_err++; $display("FAIL err_wait_psel: got %b want 000", e_mpsel); end
      n_cmp++; if (e_pready !== 2'b00) begin n_err++; $display("FAIL err_wait_pready: got %b want 00", e_pready); end
      n_cmp++; if (e_mpaddr !== 16'h0) begin n_err++; $display("FAIL err_wait_paddr: got %h want 0", e_mpaddr); end
      next_cycle();
      e_penable = 2'b01;
      @(negedge clk);
      n_cmp++; if (e_pready !== 2'b01) begin n_err++; $display("FAIL err_pready: got %b want 01", e_pready); end
      n_cmp++; if (e_pslverr !== 2'b01) begin n_err++; $display("FAIL err_pslverr: got %b want 01", e_pslverr); end
      n_cmp++; if (e_prdata !== 32'h0) begin n_err++; $display("FAIL err_prdata: got %h want 0", e_prdata); end
      n_cmp++; if (e_mpsel !== 3'b000) begin n_err++; $display("FAIL err_psel: got %b want 000", e_mpsel); end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      n_cmp++; if ({e_pready, e_pslverr} !== 4'b0000) begin n_err++; $display("FAIL err_after: got %b/%b want 00/00", e_pready, e_pslverr); end
      next_cycle();
   endtask

   // Master abandons the request during SETUP; downstream transfer still finishes.
   task automatic test_drop_mid();
      clear_inputs();
      s_paddr[15:0]  = 16'h1000;
      s_pwdata[15:0] = 16'h5A5A;
      s_pwrite = 2'b01;
      s_psel   = 2'b01;
      @(negedge clk);
      next_cycle();
      s_psel = 2'b00;
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b0010) begin n_err++; $display("FAIL drop_setup_psel: got %b want 0010", m_psel); end
      n_cmp++; if (m_paddr !== 16'h1000) begin n_err++; $display("FAIL drop_setup_paddr: got %h want 1000", m_paddr); end
      next_cycle();
      @(negedge clk);
      n_cmp++; if ({m_psel, m_penable} !== 5'b0010_1) begin n_err++; $display("FAIL drop_acc: got %b/%b want 0010/1", m_psel, m_penable); end
      next_cycle();
      m_pready = 4'b0010;
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b0010) begin n_err++; $display("FAIL drop_done_psel: got %b want 0010", m_psel); end
      n_cmp++; if (s_pready !== 2'b00) begin n_err++; $display("FAIL drop_done_pready: got %b want 00", s_pready); end
      next_cycle();
      m_pready = 4'b0000;
      @(negedge clk);
      n_cmp++; if ({m_psel, m_penable} !== 5'b0000_0) begin n_err++; $display("FAIL drop_idle: got %b/%b want 0000/0", m_psel, m_penable); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_timeout();
      int         hit;
      logic [3:0] last_psel;
      hit = 0;
      last_psel = '0;
      clear_inputs();
      s_paddr  = {16'h2008, 16'h0000};
      s_psel   = 2'b10;
      m_pready = 4'b1011;
      m_prdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      @(negedge clk);
      next_cycle();
      s_penable = 2'b10;
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b0100) begin n_err++; $display("FAIL to_setup_psel: got %b want 0100", m_psel); end
      next_cycle();
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (s_pready !== 2'b00) begin
            hit = k;
            break;
         end
         last_psel = m_psel;
         next_cycle();
      end
      n_cmp++; if (hit != 255) begin n_err++; $display("FAIL to_cycle: got %0d want 255", hit); end
      n_cmp++; if (s_pready !== 2'b10) begin n_err++; $display("FAIL to_pready: got %b want 10", s_pready); end
      n_cmp++; if (s_pslverr !== 2'b10) begin n_err++; $display("FAIL to_pslverr: got %b want 10", s_pslverr); end
      n_cmp++; if (s_prdata !== 32'h0) begin n_err++; $display("FAIL to_prdata: got %h want 0", s_prdata); end
      n_cmp++; if (m_psel !== 4'b0000) begin n_err++; $display("FAIL to_psel: got %b want 0000", m_psel); end
      n_cmp++; if (last_psel !== 4'b0100) begin n_err++; $display("FAIL to_wait_psel: got %b want 0100", last_psel); end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      n_cmp++; if ({m_psel, s_pready} !== 6'b0) begin n_err++; $display("FAIL to_idle: got %b/%b want 0000/00", m_psel, s_pready); end
      next_cycle();
   endtask

   task automatic test_reset_mid_access();
      clear_inputs();
      s_paddr = {16'h1000, 16'h3000};
      s_psel  = 2'b01;
      @(negedge clk);
      next_cycle();
      s_penable = 2'b01;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b1000) begin n_err++; $display("FAIL rst_acc_psel: got %b want 1000", m_psel); end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (m_psel !== 4'b0000) begin n_err++; $display("FAIL rst_async_psel: got %b want 0000", m_psel); end
      n_cmp++; if (s_pready !== 2'b00) begin n_err++; $display("FAIL rst_async_pready: got %b want 00", s_pready); end
      n_cmp++; if ({m_penable, m_paddr} !== 17'h0) begin n_err++; $display("FAIL rst_async_mbus: got %b/%h want 0/0", m_penable, m_paddr); end
      s_psel    = 2'b11;
      s_penable = 2'b00;
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b0000) begin n_err++; $display("FAIL rst_idle_psel: got %b want 0000", m_psel); end
      next_cycle();
      s_penable = 2'b11;
      @(negedge clk);
      n_cmp++; if (m_psel !== 4'b1000) begin n_err++; $display("FAIL rst_first_psel: got %b want 1000", m_psel); end
      n_cmp++; if (m_paddr !== 16'h3000) begin n_err++; $display("FAIL rst_first_paddr: got %h want 3000", m_paddr); end
      next_cycle();
      m_pready = 4'b1111;
      @(negedge clk);
      n_cmp++; if (s_pready !== 2'b01) begin n_err++; $display("FAIL rst_first_pready: got %b want 01", s_pready); end
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_write();
      test_err();
      test_drop_mid();
      test_timeout();
      test_reset_mid_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout want completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
